// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART receiver and transmitter.
//   rx_state_e        : receiver FSM state encoding (3 bits)
//   pulse_width()     : clocks per serial bit for a given clk / baud pair
//   half_pulse_width(): clocks from a start-bit edge to mid-bit
//   cnt_width()       : counter width able to hold 0..n-1, never below 1 bit
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic int pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int half_pulse_width(input int clk_freq, input int baud_rate);
    return pulse_width(clk_freq, baud_rate) / 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync -- two-flop synchroniser for a single asynchronous input.
//   clk  : destination clock
//   rstn : synchronous, active-low reset; both flops load RST_VAL
//   d    : asynchronous input
//   q    : synchronised output (two clk of latency)
// RST_VAL lets an idle-high line come out of reset without a false edge.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1-style UART receiver with valid/ready byte delivery.
//   clk       : system clock
//   rstn      : synchronous, active-low reset (aborts any frame in flight)
//   rx_sig    : asynchronous serial line, idle high
//   data      : received byte, held stable while valid=1 and ready=0
//   valid     : data holds an unconsumed byte
//   ready     : consumer takes data on a cycle with valid & ready
//   frame_err : one-cycle pulse when the stop bit is sampled low
//   overrun   : one-cycle pulse when a byte completes while valid=1, ready=0
// The line is synchronised, the start bit is confirmed at mid-bit, each data
// bit is sampled at mid-bit (LSB first) and the stop bit is checked before
// the byte is offered downstream.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  import uart_pkg::*;

  localparam int PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PULSE_WIDTH = half_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W            = cnt_width(PULSE_WIDTH);
  localparam int BIT_W            = cnt_width(DATA_WIDTH);

  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_PULSE_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

  logic sig_s;

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx_sig),
    .q    (sig_s)
  );

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  cnt_zero;

  assign cnt_zero = (clk_cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    // A consumed byte drops valid; a byte loading this cycle overrides below.
    valid_d     = valid_q & ~ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (!cnt_zero && (state_q == RX_START || state_q == RX_DATA || state_q == RX_STOP)) begin
      clk_cnt_d = clk_cnt_q - 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (!sig_s) begin
          state_d   = RX_START;
          clk_cnt_d = HALF_RELOAD;
        end
      end

      RX_START: begin
        if (cnt_zero) begin
          if (!sig_s) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
            clk_cnt_d = FULL_RELOAD;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_d = RX_IDLE;
          end
        end
      end

      RX_DATA: begin
        if (cnt_zero) begin
          // LSB arrives first, so shifting right leaves it in bit 0.
          shift_d   = {sig_s, shift_q[DATA_WIDTH-1:1]};
          clk_cnt_d = FULL_RELOAD;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      RX_STOP: begin
        if (cnt_zero) begin
          if (sig_s) begin
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              // Held byte is still pending: keep it and drop the new one.
              overrun_d = 1'b1;
            end
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end

      // Wait out a held-low line so it yields one frame_err, not a stream.
      RX_BREAK: begin
        if (sig_s) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Shift register is pure datapath: it is fully rewritten by every frame.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx.
// Clock is scaled so one bit is 16 clocks at 115200 baud, keeping runs short.
module tb_uart_rx;

  localparam int DW   = 8;
  localparam int BAUD = 115200;
  localparam int CLKF = 1_843_200;
  localparam int P    = CLKF / BAUD;
  localparam int H    = P / 2;
  // Sampling edge (counted from the edge that first sees rx low) at which valid reads 1.
  localparam int LAT  = 2 + H + (DW + 1) * P + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx_sig = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          overrun;

  uart_rx #(
    .DATA_WIDTH (DW),
    .BAUD_RATE  (BAUD),
    .CLK_FREQ   (CLKF)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_sig    (rx_sig),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  int         ferr_cnt;
  int         ovr_cnt;
  int         vld_cyc;
  int         hold_viol = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;
  int         lat;

  // Monitor on the falling edge: records handshakes, flag pulses and
  // any change of data while a byte is being held back.
  always @(negedge clk) begin
    if (rstn) begin
      if (valid && ready) got_q.push_back(data);
      if (valid) vld_cyc++;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (prev_hold && valid && data !== prev_data) hold_viol++;
    end
    prev_hold = rstn && valid && !ready;
    prev_data = data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    vld_cyc  = 0;
  endtask

  // Drives one frame; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop_hi);
    rx_sig = 1'b0;
    tick(P);
    for (int i = 0; i < DW; i++) begin
      rx_sig = b[i];
      tick(P);
    end
    rx_sig = stop_hi;
    tick(P);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_hi;
    int         hold_low;
    int         exp_n;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[4];

  logic [7:0] exp_q[$];
  int         exp_ferr;

  initial begin
    vecs[0] = '{b: 8'h5A, stop_hi: 1'b1, hold_low: 0,   exp_n: 1, exp_ferr: 0};
    vecs[1] = '{b: 8'h3C, stop_hi: 1'b0, hold_low: 200, exp_n: 0, exp_ferr: 1};
    vecs[2] = '{b: 8'hC3, stop_hi: 1'b1, hold_low: 0,   exp_n: 1, exp_ferr: 0};
    vecs[3] = '{b: 8'h81, stop_hi: 1'b1, hold_low: 0,   exp_n: 1, exp_ferr: 0};

    // Reset state
    clear_mon();
    tick(5);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    rstn = 1'b1;
    tick(5);
    ready = 1'b1;

    // Single frame with latency measurement
    clear_mon();
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int cyc;
        cyc = 0;
        while (cyc < LAT + 40) begin
          @(negedge clk);
          if (valid && lat < 0) lat = cyc;
          @(posedge clk);
          cyc++;
        end
      end
    join
    #1;
    chk("a5_latency", lat, LAT);
    chk("a5_count", got_q.size(), 1);
    chk("a5_data", got_q[0], 8'hA5);
    chk("a5_valid_cycles", vld_cyc, 1);
    chk("a5_flags", ferr_cnt + ovr_cnt, 0);

    // Back-to-back frames, no idle gap
    clear_mon();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    chk("b2b_count", got_q.size(), 2);
    chk("b2b_first", got_q[0], 8'h00);
    chk("b2b_second", got_q[1], 8'hFF);
    chk("b2b_overrun", ovr_cnt, 0);

    // Short low glitch on an idle line
    clear_mon();
    rx_sig = 1'b0;
    tick(H - 3);
    rx_sig = 1'b1;
    tick(3 * P);
    chk("glitch_count", got_q.size(), 0);
    chk("glitch_ferr", ferr_cnt, 0);

    // Table of frames, including a stop-low frame on a held-low line
    for (int v = 0; v < 4; v++) begin
      clear_mon();
      send_frame(vecs[v].b, vecs[v].stop_hi);
      if (vecs[v].hold_low > 0) begin
        rx_sig = 1'b0;
        tick(vecs[v].hold_low);
      end
      rx_sig = 1'b1;
      tick(20);
      chk($sformatf("vec%0d_count", v), got_q.size(), vecs[v].exp_n);
      if (vecs[v].exp_n > 0) chk($sformatf("vec%0d_data", v), got_q[0], vecs[v].b);
      chk($sformatf("vec%0d_ferr", v), ferr_cnt, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_ovr", v), ovr_cnt, 0);
    end

    // Overrun: consumer stalled across two frames
    clear_mon();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(5);
    chk("ovr_valid_held", valid, 1);
    chk("ovr_data_held", data, 8'h11);
    chk("ovr_pulses", ovr_cnt, 1);
    chk("ovr_none_taken", got_q.size(), 0);
    ready = 1'b1;
    tick(3);
    chk("ovr_taken_count", got_q.size(), 1);
    chk("ovr_taken_data", got_q[0], 8'h11);
    chk("ovr_valid_clear", valid, 0);

    // Reset in the middle of the data bits of 0x77
    clear_mon();
    rx_sig = 1'b0;
    tick(P);
    for (int i = 0; i < 3; i++) begin
      rx_sig = 1'b1;
      tick(P);
    end
    rstn = 1'b0;
    tick(1);
    chk("midrst_data", data, 0);
    tick(4);
    rstn = 1'b1;
    rx_sig = 1'b1;
    tick(20 * P);
    chk("midrst_count", got_q.size(), 0);
    chk("midrst_flags", ferr_cnt + ovr_cnt, 0);
    chk("midrst_valid", valid, 0);
    clear_mon();
    send_frame(8'h99, 1'b1);
    tick(20);
    chk("post_rst_count", got_q.size(), 1);
    chk("post_rst_data", got_q[0], 8'h99);

    // Randomised frames against a queue-based reference
    clear_mon();
    exp_q.delete();
    exp_ferr = 0;
    for (int f = 0; f < 25; f++) begin
      logic [7:0] b;
      logic       bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, !bad);
      if (bad) begin
        exp_ferr++;
        tick($urandom_range(0, 30));
        rx_sig = 1'b1;
        tick($urandom_range(3, 20));
      end else begin
        exp_q.push_back(b);
        tick($urandom_range(0, 20));
      end
    end
    tick(20);
    chk("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("rand_data%0d", i), got_q[i], exp_q[i]);
    end
    chk("rand_ferr", ferr_cnt, exp_ferr);
    chk("rand_ovr", ovr_cnt, 0);

    chk("data_hold_stable", hold_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the companion of the team's UART transmitter, on the same 8N1 serial line format: idle high, one start bit (low), DATA_WIDTH data bits LSB first, one stop bit (high). Synchronises the asynchronous serial input, detects the start bit, samples each bit at mid-period and checks the stop bit. Delivers each byte over a valid/ready handshake to the consumer (FIFO or command decoder). Sits on the device side of the serial pin, alongside the transmitter.

Parameters:
DATA_WIDTH, 8, data bits per frame
BAUD_RATE, 115200, line bit rate
CLK_FREQ, 100_000_000, clk frequency in Hz
PULSE_WIDTH (local), CLK_FREQ/BAUD_RATE, clocks per bit (868 at defaults)
HALF_PULSE_WIDTH (local), PULSE_WIDTH/2, clocks to mid-bit (434 at defaults)

Ports:
clk  input  1  system clock
rstn  input  1  reset, synchronous, active-low
rx_sig  input  1  asynchronous serial line
data  output  DATA_WIDTH  received byte; stable while valid=1
valid  output  1  data holds an unconsumed byte
ready  input  1  consumer accepts data when valid&ready
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while valid=1 and ready=0

Behaviour:
- Reset: valid=0, data=0, frame_err=0, overrun=0, state IDLE, both synchroniser flops=1, counters=0.
- rx_sig passes through a 2-flop synchroniser; all logic uses the synchronised sig_s. Reset mid-frame aborts the frame with no output.
- IDLE: sig_s==0 -> START, clk_cnt<=HALF_PULSE_WIDTH-1.
- Every timed state decrements clk_cnt while >0 and acts on the cycle clk_cnt==0.
- START at 0: sig_s==0 -> DATA, bit_cnt<=0, clk_cnt<=PULSE_WIDTH-1. sig_s==1 -> glitch, back to IDLE, no flags.
- DATA at 0: shift sig_s into the MSB of shift register (shift right); reload PULSE_WIDTH-1. bit_cnt==DATA_WIDTH-1 -> STOP, else bit_cnt+1.
- STOP at 0:
  - sig_s==1 and (valid==0 or ready==1): data<=shift, valid<=1 next cycle; -> IDLE.
  - sig_s==1, valid==1, ready==0: new byte dropped, data/valid unchanged, overrun pulses 1 cycle; -> IDLE.
  - sig_s==0: frame_err pulses 1 cycle, byte discarded; -> BREAK.
- BREAK: wait for sig_s==1, then -> IDLE. A held-low line produces exactly one frame_err.
- Handshake: valid deasserts the cycle after valid&ready, unless a new byte loads that same cycle; then valid stays 1 with new data. data never changes while valid=1 and ready=0.
- Latency: rx_sig falling edge sampled at cycle 0 -> valid=1 at cycle 2+HALF_PULSE_WIDTH+(DATA_WIDTH+1)*PULSE_WIDTH+1 = 8249 at defaults.
- Counter widths: clk_cnt $clog2(PULSE_WIDTH) bits; bit_cnt $clog2(DATA_WIDTH) bits; no wrap occurs within a frame.
- State enum: IDLE, START, DATA, STOP, BREAK (3 bits); undefined encodings -> IDLE.

Decomposition:
- Shared package uart_pkg: rx state typedef, timing function computing PULSE_WIDTH/HALF_PULSE_WIDTH from CLK_FREQ and BAUD_RATE (shared with the transmitter).
- One sub-module: uart_sync (2-flop synchroniser, reset value 1, parameterised reset level).

Test Plan:
- Send 0xA5 at 115200 baud, ready=1 -> valid high at cycle 8249 after the falling edge, data=0xA5 for 1 cycle, no flags.
- Back-to-back frames 0x00 then 0xFF, no idle gap, ready=1 -> two valid pulses, data 0x00 then 0xFF, no overrun.
- Low glitch of 300 clocks on idle line -> no valid, no frame_err; following 0x5A frame received correctly.
- Frame 0x3C with stop bit forced low, line then held low 2000 clocks, then high -> single frame_err pulse, no valid; next frame 0xC3 received correctly.
- ready=0, send 0x11 then 0x22 -> data=0x11 with valid held; overrun pulses at the second stop bit; ready=1 then consumes 0x11.
- rstn low for 5 cycles mid-data of 0x77 -> valid=0, no flags; next full frame 0x99 received correctly.
